// File: rtl/mu0_mem_arbiter.sv
// Purpose : single-port RAM arbiter between the MU0 core and a debug/loader port.
//           The core has priority; the debug port is granted idle cycles, a forced
//           slot after MAXWAIT consecutive denials (fair build only), or exclusive
//           ownership of the RAM while the core is halted.
// Latency : arbitration and mem_* strobes are combinational (grant in the request
//           cycle); dbg_rvalid is registered one cycle after a granted debug read.
// Backpressure : the core is held off with cpu_stall; a debug request is held
//           stable by the requester until dbg_gnt.
//
// Ports   : clk, reset (sync, active-high)
//           cpu_ren/cpu_wen/cpu_addr/cpu_wdata -> cpu_rdata, cpu_stall
//           dbg_req/dbg_we/dbg_addr/dbg_wdata  -> dbg_gnt, dbg_rdata, dbg_rvalid
//           dbg_halt -> cpu_halted
//           mem_ren/mem_wen/mem_addr/mem_wdata <- mem_rdata (RAM, 1-cycle read)
// Config  : define MU0_ARB_FAIR_EN to enable the debug starvation guard (wait_cnt).
//           Without it the core has strict priority while running.

module mu0_mem_arbiter #(
   parameter int AW      = 12,
   parameter int DW      = 16,
   parameter int MAXWAIT = 4
) (
   input  logic          clk,
   input  logic          reset,

   input  logic          cpu_ren,
   input  logic          cpu_wen,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic [DW-1:0] cpu_rdata,
   output logic          cpu_stall,

   input  logic          dbg_req,
   input  logic          dbg_we,
   input  logic [AW-1:0] dbg_addr,
   input  logic [DW-1:0] dbg_wdata,
   output logic          dbg_gnt,
   output logic [DW-1:0] dbg_rdata,
   output logic          dbg_rvalid,

   input  logic          dbg_halt,
   output logic          cpu_halted,

   output logic          mem_ren,
   output logic          mem_wen,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
);

   // A zero MAXWAIT would make the guard fire on every contended cycle,
   // i.e. silently invert the priority.
   if (MAXWAIT < 1) begin : g_maxwait_chk
      $error("mu0_mem_arbiter: MAXWAIT must be >= 1");
   end

   localparam logic [0:0] ST_RUN  = 1'b0;
   localparam logic [0:0] ST_HALT = 1'b1;

   logic [0:0] state_q, state_d;
   logic       dbg_rvalid_q, dbg_rvalid_d;

   logic       core_acc;
   logic       owner_cpu;
   logic       owner_dbg;
   logic       wait_expired;

   assign core_acc = cpu_ren | cpu_wen;

`ifdef MU0_ARB_FAIR_EN
   localparam int WW = $clog2(MAXWAIT + 1);
   localparam logic [WW-1:0] WAIT_MAX = WW'(MAXWAIT);

   logic [WW-1:0] wait_cnt_q, wait_cnt_d;

   assign wait_expired = (wait_cnt_q == WAIT_MAX);

   // Counts consecutive cycles in which a pending debug request lost to the
   // core. Any gap in the request or any grant restarts the count.
   always_comb begin
      wait_cnt_d = wait_cnt_q;
      if (!dbg_req || owner_dbg) begin
         wait_cnt_d = '0;
      end else if (wait_cnt_q != WAIT_MAX) begin
         wait_cnt_d = wait_cnt_q + WW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wait_cnt_q <= '0;
      end else begin
         wait_cnt_q <= wait_cnt_d;
      end
   end
`else
   // Strict core priority: debug never preempts a running core.
   assign wait_expired = 1'b0;
`endif

   // Ownership. In HALT the core is shut out completely, even when the debug
   // port is idle, so the controller sees a frozen memory.
   always_comb begin
      owner_dbg = 1'b0;
      owner_cpu = 1'b0;
      if (state_q == ST_HALT) begin
         owner_dbg = dbg_req;
      end else begin
         owner_dbg = dbg_req & (~core_acc | wait_expired);
         owner_cpu = core_acc & ~owner_dbg;
      end
   end

   // RAM port mux. Address/data follow the core when nobody owns the RAM;
   // the strobes are what matter in that case.
   always_comb begin
      mem_ren   = 1'b0;
      mem_wen   = 1'b0;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      if (owner_cpu) begin
         // A simultaneous read and write from the core resolves as a write.
         mem_wen = cpu_wen;
         mem_ren = cpu_ren & ~cpu_wen;
      end else if (owner_dbg) begin
         mem_wen   = dbg_we;
         mem_ren   = ~dbg_we;
         mem_addr  = dbg_addr;
         mem_wdata = dbg_wdata;
      end
   end

   assign dbg_gnt   = owner_dbg;
   assign cpu_stall = core_acc & ~owner_cpu;

   // Both clients see the raw RAM output; each qualifies it with its own
   // knowledge of whether it issued a read last cycle.
   assign cpu_rdata = mem_rdata;
   assign dbg_rdata = mem_rdata;

   // Halt request is followed one cycle later in both directions.
   always_comb begin
      state_d = dbg_halt ? ST_HALT : ST_RUN;
   end

   always_comb begin
      dbg_rvalid_d = owner_dbg & ~dbg_we;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_RUN;
         dbg_rvalid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         dbg_rvalid_q <= dbg_rvalid_d;
      end
   end

   assign dbg_rvalid = dbg_rvalid_q;
   assign cpu_halted = (state_q == ST_HALT);

endmodule

// File: tb/tb_mu0_mem_arbiter.sv
// Bench for mu0_mem_arbiter: directed scenarios followed by randomized traffic,
// checked every cycle against a behavioural model of the arbitration rules.
// Honours MU0_ARB_FAIR_EN the same way the design does.

module tb_mu0_mem_arbiter;

   localparam int AW      = 12;
   localparam int DW      = 16;
   localparam int MAXWAIT = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          cpu_ren, cpu_wen;
   logic [AW-1:0] cpu_addr;
   logic [DW-1:0] cpu_wdata;
   logic [DW-1:0] cpu_rdata;
   logic          cpu_stall;
   logic          dbg_req, dbg_we;
   logic [AW-1:0] dbg_addr;
   logic [DW-1:0] dbg_wdata;
   logic          dbg_gnt;
   logic [DW-1:0] dbg_rdata;
   logic          dbg_rvalid;
   logic          dbg_halt;
   logic          cpu_halted;
   logic          mem_ren, mem_wen;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;

   always #5 clk = ~clk;

   mu0_mem_arbiter #(.AW(AW), .DW(DW), .MAXWAIT(MAXWAIT)) dut (
      .clk(clk), .reset(reset),
      .cpu_ren(cpu_ren), .cpu_wen(cpu_wen), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
      .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
      .dbg_gnt(dbg_gnt), .dbg_rdata(dbg_rdata), .dbg_rvalid(dbg_rvalid),
      .dbg_halt(dbg_halt), .cpu_halted(cpu_halted),
      .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   // ---------------- RAM behind the arbiter ----------------
   function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
      if (a == 12'h010) return 16'h1234;
      return DW'({4'd0, a} * 16'd37 + 16'd5);
   endfunction

   logic          init_go;
   logic [DW-1:0] ram [0:4095];

   always @(posedge clk) begin
      if (init_go) begin
         for (int i = 0; i < 4096; i++) ram[i] <= init_val(i[AW-1:0]);
      end else begin
         if (mem_wen) ram[mem_addr] <= mem_wdata;
         if (mem_ren) mem_rdata <= ram[mem_addr];
      end
   end

   // ---------------- checking ----------------
   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // ---------------- reference model ----------------
   bit            m_halted;
   int            m_wait;      // consecutive cycles a pending debug request lost
   bit            m_rv;        // debug read data due this cycle
   logic [DW-1:0] m_rd;
   bit            m_crv;       // core read data due this cycle
   logic [DW-1:0] m_crd;
   bit            m_last_dw;
   logic [DW-1:0] shadow [0:4095];

   logic          obs_gnt, obs_stall, obs_rvalid, obs_halted, obs_wen, obs_ren;
   logic [DW-1:0] obs_rdata, obs_cpu_rdata;

   task automatic idle();
      cpu_ren = 0; cpu_wen = 0; cpu_addr = '0; cpu_wdata = '0;
      dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;
   endtask

   // One clock: inputs are already applied; check at the falling edge, then
   // advance the model to what the rising edge should produce.
   task automatic step();
      bit            core, dw, cw;
      logic          e_wen, e_ren;
      logic [AW-1:0] ea;
      logic [DW-1:0] ed;
      @(negedge clk);
      core = (cpu_ren | cpu_wen);
      if (m_halted) begin
         dw = dbg_req;
         cw = 0;
      end else begin
`ifdef MU0_ARB_FAIR_EN
         dw = dbg_req && (!core || m_wait >= MAXWAIT);
`else
         dw = dbg_req && !core;
`endif
         cw = core && !dw;
      end
      e_wen = 0; e_ren = 0; ea = '0; ed = '0;
      if (cw) begin
         e_wen = cpu_wen; e_ren = cpu_ren && !cpu_wen; ea = cpu_addr; ed = cpu_wdata;
      end else if (dw) begin
         e_wen = dbg_we; e_ren = !dbg_we; ea = dbg_addr; ed = dbg_wdata;
      end

      chk("dbg_gnt",    32'(dbg_gnt),    32'(dw));
      chk("cpu_stall",  32'(cpu_stall),  32'(core && !cw));
      chk("mem_wen",    32'(mem_wen),    32'(e_wen));
      chk("mem_ren",    32'(mem_ren),    32'(e_ren));
      if (e_wen || e_ren) chk("mem_addr", 32'(mem_addr), 32'(ea));
      if (e_wen)          chk("mem_wdata", 32'(mem_wdata), 32'(ed));
      chk("cpu_halted", 32'(cpu_halted), 32'(m_halted));
      chk("dbg_rvalid", 32'(dbg_rvalid), 32'(m_rv));
      if (m_rv)  chk("dbg_rdata", 32'(dbg_rdata), 32'(m_rd));
      if (m_crv) chk("cpu_rdata", 32'(cpu_rdata), 32'(m_crd));

      obs_gnt = dbg_gnt; obs_stall = cpu_stall; obs_rvalid = dbg_rvalid;
      obs_halted = cpu_halted; obs_wen = mem_wen; obs_ren = mem_ren;
      obs_rdata = dbg_rdata; obs_cpu_rdata = cpu_rdata;

      m_last_dw = dw;
      m_crv = cw && e_ren;
      if (e_ren) begin
         m_rd  = shadow[ea];
         m_crd = shadow[ea];
      end
      if (e_wen) shadow[ea] = ed;
      if (!dbg_req || dw) m_wait = 0;
      else if (m_wait < MAXWAIT) m_wait = m_wait + 1;
      if (reset) begin
         m_halted = 0; m_wait = 0; m_rv = 0;
      end else begin
         m_halted = dbg_halt;
         m_rv = dw && !dbg_we;
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int first_gnt, gnt_cnt, stall_cnt;

      idle(); dbg_halt = 0; reset = 1; init_go = 1;
      for (int i = 0; i < 4096; i++) shadow[i] = init_val(i[AW-1:0]);
      m_halted = 0; m_wait = 0; m_rv = 0; m_crv = 0; m_rd = '0; m_crd = '0; m_last_dw = 0;
      @(posedge clk); #1;
      init_go = 0;
      step();                          // reset held, all inputs low
      chk("rst_rvalid", 32'(obs_rvalid), 32'd0);
      chk("rst_halted", 32'(obs_halted), 32'd0);
      reset = 0;
      step();

      // Idle core, debug read of 0x010.
      dbg_req = 1; dbg_we = 0; dbg_addr = 12'h010;
      step();
      chk("idle_rd_gnt", 32'(obs_gnt), 32'd1);
      chk("idle_rd_stall", 32'(obs_stall), 32'd0);
      idle();
      step();
      chk("idle_rd_rvalid", 32'(obs_rvalid), 32'd1);
      chk("idle_rd_data", 32'(obs_rdata), 32'h1234);

      // Core reading every cycle while debug waits.
      first_gnt = -1; gnt_cnt = 0; stall_cnt = 0;
      for (int i = 0; i < 6; i++) begin
         cpu_ren = 1; cpu_addr = AW'($urandom_range(0, 63));
         dbg_req = 1; dbg_we = 0; dbg_addr = 12'h010;
         step();
         if (obs_gnt && first_gnt < 0) first_gnt = i;
         gnt_cnt += int'(obs_gnt);
         stall_cnt += int'(obs_stall);
      end
`ifdef MU0_ARB_FAIR_EN
      chk("starve_first_gnt", 32'(first_gnt), 32'(MAXWAIT));
      chk("starve_gnt_cnt", 32'(gnt_cnt), 32'd1);
      chk("starve_stall_cnt", 32'(stall_cnt), 32'd1);
`else
      chk("strict_first_gnt", 32'(first_gnt), 32'hFFFF_FFFF);
      chk("strict_gnt_cnt", 32'(gnt_cnt), 32'd0);
      chk("strict_stall_cnt", 32'(stall_cnt), 32'd0);
`endif
      idle();
      step();
      step();

      // Core write and debug write collide with no accumulated wait.
      cpu_wen = 1; cpu_addr = 12'h020; cpu_wdata = 16'h00AA;
      dbg_req = 1; dbg_we = 1; dbg_addr = 12'h030; dbg_wdata = 16'h5555;
      step();
      chk("coll_gnt", 32'(obs_gnt), 32'd0);
      chk("coll_stall", 32'(obs_stall), 32'd0);
      chk("coll_wen", 32'(obs_wen), 32'd1);
      cpu_wen = 0;
      step();
      chk("coll_gnt_next", 32'(obs_gnt), 32'd1);
      idle(); cpu_ren = 1; cpu_addr = 12'h020;
      step();
      idle();
      step();
      chk("coll_core_rd", 32'(obs_cpu_rdata), 32'h00AA);

      // Halt: debug owns the RAM, core stalls on every request.
      dbg_halt = 1;
      step();
      cpu_ren = 1; cpu_addr = 12'h001;
      step();
      chk("halt_flag", 32'(obs_halted), 32'd1);
      chk("halt_stall_rd", 32'(obs_stall), 32'd1);
      dbg_req = 1; dbg_we = 1; dbg_addr = 12'h001; dbg_wdata = 16'h0005;
      step();
      chk("halt_wr_gnt", 32'(obs_gnt), 32'd1);
      cpu_ren = 0; cpu_wen = 1; cpu_wdata = 16'hDEAD;
      dbg_we = 0;
      step();
      chk("halt_stall_wr", 32'(obs_stall), 32'd1);
      idle();
      step();
      chk("halt_rb_rvalid", 32'(obs_rvalid), 32'd1);
      chk("halt_rb_data", 32'(obs_rdata), 32'h0005);
      dbg_halt = 0;
      step();
      chk("unhalt_lag", 32'(obs_halted), 32'd1);
      cpu_ren = 1; cpu_addr = 12'h001;
      step();
      chk("unhalt_flag", 32'(obs_halted), 32'd0);
      chk("unhalt_stall", 32'(obs_stall), 32'd0);

      // Core read and write together resolve as a write.
      idle(); cpu_ren = 1; cpu_wen = 1; cpu_addr = 12'h040; cpu_wdata = 16'hBEEF;
      step();
      chk("rw_wen", 32'(obs_wen), 32'd1);
      chk("rw_ren", 32'(obs_ren), 32'd0);

      // Reset right after a granted debug read in HALT.
      idle(); dbg_halt = 1;
      step();
      dbg_req = 1; dbg_we = 0; dbg_addr = 12'h010;
      step();
      idle(); reset = 1;
      step();
      reset = 0; dbg_halt = 0; cpu_ren = 1; cpu_addr = 12'h002;
      step();
      chk("rst_mid_rvalid", 32'(obs_rvalid), 32'd0);
      chk("rst_mid_halted", 32'(obs_halted), 32'd0);
      chk("rst_mid_stall", 32'(obs_stall), 32'd0);
      idle();
      step();

      // Randomized traffic. A pending debug request stays stable until granted.
      for (int c = 0; c < 800; c++) begin
         if (!(dbg_req && !m_last_dw)) begin
            dbg_req   = ($urandom_range(0, 2) == 0);
            dbg_we    = $urandom_range(0, 1) == 1;
            dbg_addr  = AW'($urandom_range(0, 31));
            dbg_wdata = DW'($urandom);
         end
         cpu_ren   = ($urandom_range(0, 3) != 0);
         cpu_wen   = ($urandom_range(0, 4) == 0);
         cpu_addr  = AW'($urandom_range(0, 31));
         cpu_wdata = DW'($urandom);
         if ($urandom_range(0, 40) == 0) dbg_halt = ~dbg_halt;
         reset = ($urandom_range(0, 150) == 0);
         step();
      end
      reset = 0;
      idle();
      step();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
